// File: rtl/logic_unit_n_bits.sv
// Registered N-bit bitwise logic unit (AND/OR/XOR/NAND) with a pair mode and a
// fold mode that reduces a packet of up to MAX_BEATS operands into one result.
module logic_unit_n_bits #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 4,
  parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  input  logic             mode,
  input  logic             last,
  output logic [WIDTH-1:0] X,
  output logic             out_valid,
  output logic             red_and,
  output logic             red_or,
  output logic [CNT_W-1:0] beats,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FOLD = 2'd1,
    EMIT = 2'd2
  } state_t;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_x;
  logic             r_red_and;
  logic             r_red_or;
  logic [CNT_W-1:0] r_beats;
  logic             r_ovf;
  logic             r_out_valid;

  logic             w_accept;
  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_lhs;
  logic [WIDTH-1:0] w_rhs;
  logic [WIDTH-1:0] w_res;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_fold_done;

  // The first beat of a packet uses the live op and A/B; later beats fold A into
  // the accumulator with the op captured on that first beat.
  assign w_op  = (r_state == IDLE) ? op : r_op;
  assign w_lhs = (r_state == IDLE) ? A  : r_acc;
  assign w_rhs = (r_state == IDLE) ? B  : A;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
      assign w_res[gi] = (w_op == OP_AND) ?  (w_lhs[gi] & w_rhs[gi]) :
                         (w_op == OP_OR)  ?  (w_lhs[gi] | w_rhs[gi]) :
                         (w_op == OP_XOR) ?  (w_lhs[gi] ^ w_rhs[gi]) :
                                            ~(w_lhs[gi] & w_rhs[gi]);
    end
  endgenerate

  assign in_ready    = !rst && (r_state != EMIT);
  assign w_accept    = in_valid && in_ready;
  assign w_cnt_next  = r_cnt + CNT_W'(1);
  assign w_fold_done = last || (w_cnt_next == CNT_W'(MAX_BEATS));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_op        <= OP_AND;
      r_x         <= '0;
      r_red_and   <= 1'b0;
      r_red_or    <= 1'b0;
      r_beats     <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (!mode || last) begin
              r_x         <= w_res;
              r_red_and   <= &w_res;
              r_red_or    <= |w_res;
              r_beats     <= CNT_W'(1);
              r_ovf       <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_acc   <= w_res;
              r_cnt   <= CNT_W'(1);
              r_op    <= op;
              r_state <= FOLD;
            end
          end
        end
        FOLD: begin
          if (w_accept) begin
            r_acc <= w_res;
            r_cnt <= w_cnt_next;
            if (w_fold_done) begin
              r_x         <= w_res;
              r_red_and   <= &w_res;
              r_red_or    <= |w_res;
              r_beats     <= w_cnt_next;
              r_ovf       <= !last;
              r_out_valid <= 1'b1;
              r_state     <= EMIT;
            end
          end
        end
        EMIT:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign X         = r_x;
  assign red_and   = r_red_and;
  assign red_or    = r_red_or;
  assign beats     = r_beats;
  assign ovf       = r_ovf;
  assign out_valid = r_out_valid;

endmodule

// File: doc/logic_unit_n_bits.md
Name: logic_unit_n_bits

Overview:
Parametrised, registered N-bit bitwise logic unit. It is the successor of the 1-bit AND gate used in the practice exercises. It selects among AND/OR/XOR/NAND and supports two modes: a single-pair mode, and a fold mode that reduces a packet of up to MAX_BEATS operands with a valid/ready input handshake. Results carry reduction flags and a beat count, for use as a lab datapath element under a testbench or a small controller.

Parameters:
WIDTH, 8, operand and result width in bits (>=1)
MAX_BEATS, 4, maximum beats per fold packet (>=2); packet force-terminates at this count
CNT_W, $clog2(MAX_BEATS+1), width of beat counter output

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand beat offered
in_ready  output  1  unit accepts beat this cycle; beat accepted when in_valid && in_ready
A  input  WIDTH  operand A
B  input  WIDTH  operand B (used only on the first beat of a packet)
op  input  2  00 AND, 01 OR, 10 XOR, 11 NAND
mode  input  1  0 pair, 1 fold
last  input  1  final beat of a fold packet (ignored in pair mode)
X  output  WIDTH  registered result
out_valid  output  1  one-cycle pulse: X/flags hold a new result
red_and  output  1  &X, registered with X
red_or  output  1  |X, registered with X
beats  output  CNT_W  number of beats folded into X (1 in pair mode)
ovf  output  1  fold packet terminated by MAX_BEATS without last

Behaviour:
- One clock domain (clk); reset is synchronous and active-high (rst). While rst=1 at a rising edge: X=0, red_and=0, red_or=0, beats=0, ovf=0, out_valid=0, state=IDLE, accumulator=0, in_ready=0. in_ready=1 from the first cycle after rst deasserts.
- States: IDLE, FOLD, EMIT. in_ready = 1 in IDLE and FOLD, 0 in EMIT and during reset.
- op and mode are sampled on the first beat of a packet and held internally. Changes on later fold beats are ignored.
- NAND = ~(a & b), full WIDTH. No carries and no width growth.
- IDLE, beat accepted with mode=0: X <= A op B, beats <= 1, ovf <= 0, out_valid pulses in the next cycle (latency 1), state stays IDLE. Back-to-back beats give a result every cycle.
- IDLE, beat with mode=1 and last=1: handled identically to pair mode (single-beat packet).
- IDLE, beat with mode=1 and last=0: acc <= A op B, count <= 1, -> FOLD. No out_valid.
- FOLD, beat accepted: acc_n = acc op A; count_n = count+1.
  - If last=1 or count_n == MAX_BEATS: X <= acc_n, beats <= count_n, ovf <= (last==0), -> EMIT.
  - Otherwise: acc <= acc_n, stay in FOLD.
- FOLD, no beat: hold everything. No timeout.
- EMIT: out_valid=1 for exactly this cycle, in_ready=0, -> IDLE next cycle.
- Pair-mode out_valid likewise lasts one cycle.
- red_and/red_or are computed from the value written to X and update in the same cycle as X.
- X, flags, beats and ovf hold their last value between results. Only out_valid pulses.
- in_valid=0 never changes state. A, B and last are don't-care when no beat is accepted.
- rst mid-packet: the packet is discarded, no out_valid is produced, and the reset values are forced.

Test Plan:
- WIDTH=8. Pair AND, A=F0, B=3C, op=00 -> next cycle: out_valid=1 for 1 cycle, X=30, red_or=1, red_and=0, beats=1, ovf=0.
- Back-to-back pairs: XOR AA,55 then NAND FF,FF on consecutive cycles -> out_valid high two consecutive cycles. First result X=FF, red_and=1. Second result X=00, red_or=0.
- Fold OR: beats (A=01,B=02), (A=04), (A=08,last=1), with op toggled to 00 on beat 2 -> X=0F, beats=3, ovf=0. out_valid appears the cycle after the last beat, and in_ready=0 in that cycle.
- Fold overflow (MAX_BEATS=4), op=00: A=FF/B=FE, then FC, F8, F0, all last=0 -> after the 4th beat X=F0, beats=4, ovf=1. A 5th beat offered during EMIT is stalled (in_ready=0) and is accepted next cycle as a new packet.
- Reset mid-fold: after 2 fold beats assert rst for 1 cycle -> no out_valid, X=00, beats=0, in_ready=0 during reset. A following pair OR 0F,F0 gives X=FF.
- Idle gaps in fold: deassert in_valid for 3 cycles between beats -> result is identical to the gapless run, and out_valid does not pulse during the gap.
